aes_block_packer: RTL



---
 rtl/aes_block_packer_pkg.sv | 33 +++
 rtl/aes_block_packer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_block_packer_pkg.sv
// ---------------------------------------------------------------------------
// Cipher_defs
//
// Shared definitions for the AES datapath: the opaque 128-bit data and key
// types handed to the combinational Cipher stage, the word/block geometry
// constants, and a small helper that maps a word index to its bit lane.
//
// Contents:
//   AES_WORD_W           width of one input word (32)
//   AES_WORDS_PER_BLOCK  words per AES block (4)
//   t_opaque_AESData     128-bit data block
//   t_opaque_AESKey      128-bit key
//   t_word_idx           index of a word within a block (0..3)
//   lane_offset()        low bit position of a word lane in a block
// ---------------------------------------------------------------------------
package Cipher_defs;

    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;
    localparam int AES_BLOCK_W         = AES_WORD_W * AES_WORDS_PER_BLOCK;

    typedef logic [AES_BLOCK_W-1:0] t_opaque_AESData;
    typedef logic [AES_BLOCK_W-1:0] t_opaque_AESKey;
    typedef logic [$clog2(AES_WORDS_PER_BLOCK)-1:0] t_word_idx;

    // With msb_first the first word lands in the top lane, so the lane number
    // is (3 - idx), which for a 2-bit index is simply its bitwise inverse.
    function automatic logic [6:0] lane_offset(input t_word_idx idx,
                                               input logic      msb_first);
        lane_offset = msb_first ? {~idx, 5'b00000} : {idx, 5'b00000};
    endfunction

endpackage

// File: rtl/aes_block_packer.sv
// ---------------------------------------------------------------------------
// aes_block_packer
//
// Packs a 32-bit word stream into 128-bit AES blocks and pairs each block
// with a snapshot of the key register. The pair is presented through a
// valid/ready output register that feeds the Cipher stage directly
// (out_data -> data, out_key -> key). A second accumulator lets the next
// block fill while the output slot is back-pressured.
//
// Parameters:
//   FIRST_WORD_MSB  1: first word in bits 127:96, 0: first word in bits 31:0
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_word    input data word
//   in_valid   in_word is valid
//   in_last    final word of a frame (qualified by in_valid)
//   in_ready   word accepted when in_valid && in_ready
//   key_in     key value
//   key_load   load key_in into the key register
//   out_data   assembled block to the cipher
//   out_key    key captured for out_data
//   out_valid  output pair is valid
//   out_ready  consumer takes the pair when out_valid && out_ready
//   err_short  one-cycle pulse when a short frame is dropped
//
// Build option:
//   AES_PACKER_PAD_EN  when defined, short frames are zero-padded to a full
//                      block instead of being dropped; err_short is tied 0.
// ---------------------------------------------------------------------------
module aes_block_packer
    import Cipher_defs::*;
#(
    parameter bit FIRST_WORD_MSB = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AES_WORD_W-1:0] in_word,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  t_opaque_AESKey        key_in,
    input  logic                  key_load,
    output t_opaque_AESData       out_data,
    output t_opaque_AESKey        out_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_short
);

    t_opaque_AESData acc;
    t_opaque_AESKey  acc_key;
    t_word_idx       cnt;
    logic            acc_full;
    t_opaque_AESKey  key_r;

    logic            accept;
    logic            last_lane;
    logic            word_done;
    logic            complete;
    logic            slot_free;
    t_opaque_AESData blk;

    assign in_ready  = !acc_full && !rst;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign last_lane = (cnt == t_word_idx'(AES_WORDS_PER_BLOCK - 1));

    // word_done: this word ends the current accumulation, either as the 4th
    // word or as the last word of a short frame.
    assign word_done = accept && (last_lane || in_last);

`ifdef AES_PACKER_PAD_EN
    // Short frames complete like a full block. The unwritten lanes of acc are
    // always zero (acc is cleared whenever a block leaves it), so blk is
    // already correctly zero-padded.
    assign complete  = word_done;
    assign err_short = 1'b0;
`else
    logic drop;

    assign complete = accept && last_lane;
    assign drop     = word_done && !last_lane;

    // Short-frame error pulse, visible the cycle after the dropping word.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_short <= 1'b0;
        end else begin
            err_short <= drop;
        end
    end
`endif

    // Current accumulator with the incoming word merged into lane cnt. This is
    // the finished block whenever complete is set.
    always_comb begin
        blk = acc;
        blk[lane_offset(cnt, FIRST_WORD_MSB) +: AES_WORD_W] = in_word;
    end

    // Accumulator, hold buffer and output slot. The pending block in acc has
    // priority for the output slot; no word can be accepted while it is
    // pending, so the branches below never compete for the same block. The
    // key register updates last so any capture this cycle sees the old key.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            acc_key   <= '0;
            cnt       <= '0;
            acc_full  <= 1'b0;
            key_r     <= '0;
            out_data  <= '0;
            out_key   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= blk;
                    cnt <= cnt + t_word_idx'(1);
                end
            end

            if (acc_full && slot_free) begin
                out_data  <= acc;
                out_key   <= acc_key;
                out_valid <= 1'b1;
                acc_full  <= 1'b0;
                acc       <= '0;
            end else if (complete && slot_free) begin
                out_data  <= blk;
                out_key   <= key_r;
                out_valid <= 1'b1;
            end else if (complete) begin
                acc      <= blk;
                acc_key  <= key_r;
                acc_full <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (key_load) begin
                key_r <= key_in;
            end
        end
    end

endmodule
